// File: rtl/ibex_pmp_csr_regs.sv
// PMP CSR register file: pmpcfg0-3, pmpaddr0-15, mseccfg/mseccfgh with full write legalisation.
// Optional bit-inverted shadow copies of all state when IBEX_PMP_CSR_SHADOW_EN is defined.

package ibex_pmp_csr_pkg;
   typedef enum logic [1:0] {
      PMP_MODE_OFF   = 2'b00,
      PMP_MODE_TOR   = 2'b01,
      PMP_MODE_NA4   = 2'b10,
      PMP_MODE_NAPOT = 2'b11
   } pmp_cfg_mode_e;

   typedef struct packed {
      logic          lock;
      pmp_cfg_mode_e mode;
      logic          exec;
      logic          write;
      logic          read;
   } pmp_cfg_t;

   typedef struct packed {
      logic rlb;
      logic mmwp;
      logic mml;
   } pmp_mseccfg_t;
endpackage

module ibex_pmp_csr_regs
   import ibex_pmp_csr_pkg::*;
#(
   parameter int unsigned PMPGranularity = 0,
   parameter int unsigned PMPNumRegions  = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         csr_we_i,
   input  logic [11:0]  csr_addr_i,
   input  logic [31:0]  csr_wdata_i,
   output logic         csr_hit_o,
   output logic [31:0]  csr_rdata_o,
   output pmp_cfg_t     csr_pmp_cfg_o [PMPNumRegions],
   output logic [33:0]  csr_pmp_addr_o [PMPNumRegions],
   output pmp_mseccfg_t csr_pmp_mseccfg_o,
   output logic         pmp_cfg_changed_o,
   output logic         shadow_err_o
);

   localparam logic [31:0] NapotMask =
      (PMPGranularity >= 2) ? ((32'd1 << (PMPGranularity - 1)) - 32'd1) : 32'd0;
   localparam logic [31:0] OffMask =
      (PMPGranularity >= 1) ? ((32'd1 << PMPGranularity) - 32'd1) : 32'd0;

   pmp_cfg_t                   cfg_q [PMPNumRegions];
   pmp_cfg_t                   cfg_d [PMPNumRegions];
   logic [31:0]                addr_q [PMPNumRegions];
   logic [31:0]                addr_d [PMPNumRegions];
   logic [31:0]                addr_rd [PMPNumRegions];
   pmp_mseccfg_t               mseccfg_q, mseccfg_d;
   logic                       changed_q, changed_d;
   logic [PMPNumRegions-1:0]   cfg_locked, addr_locked, tor_above;
   logic                       any_lock;
   logic [7:0]                 wbyte;
   logic [7:0]                 cfg_byte [16];
   logic [31:0]                addr_word [16];

   logic sel_cfg, sel_addr, sel_mseccfg, sel_mseccfgh;
   assign sel_cfg      = csr_addr_i[11:2] == 10'h0E8;
   assign sel_addr     = csr_addr_i[11:4] == 8'h3B;
   assign sel_mseccfg  = csr_addr_i == 12'h747;
   assign sel_mseccfgh = csr_addr_i == 12'h757;
   assign csr_hit_o    = sel_cfg | sel_addr | sel_mseccfg | sel_mseccfgh;

   function automatic pmp_cfg_t legalise_cfg(logic [7:0] b, pmp_cfg_t old, logic mml);
      pmp_cfg_t c;
      c.lock  = b[7];
      c.mode  = pmp_cfg_mode_e'(b[4:3]);
      c.exec  = b[2];
      c.write = b[1];
      c.read  = b[0];
      if (PMPGranularity > 0 && c.mode == PMP_MODE_NA4) c.mode = old.mode;
      // W without R is reserved; only MML gives that encoding a meaning
      if (!c.read && c.write && !mml) begin
         c.read  = 1'b0;
         c.write = 1'b0;
      end
      return c;
   endfunction

   function automatic logic [31:0] mask_addr(logic [31:0] a, pmp_cfg_mode_e m);
      if (m == PMP_MODE_NAPOT) return a | NapotMask;
      if (m == PMP_MODE_OFF || m == PMP_MODE_TOR) return a & ~OffMask;
      return a;
   endfunction

   // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
   always_comb begin
      tor_above   = '0;
      cfg_locked  = '0;
      addr_locked = '0;
      any_lock    = 1'b0;
      for (int r = 1; r < int'(PMPNumRegions); r++)
         tor_above[r-1] = cfg_q[r].lock & (cfg_q[r].mode == PMP_MODE_TOR);
      for (int r = 0; r < int'(PMPNumRegions); r++) begin
         cfg_locked[r]  = cfg_q[r].lock & ~mseccfg_q.rlb;
         addr_locked[r] = cfg_locked[r] | (tor_above[r] & ~mseccfg_q.rlb);
         any_lock       = any_lock | cfg_q[r].lock;
      end
   end

   // All legality decisions use the pre-write state, so same-word updates are independent.
   always_comb begin
      cfg_d     = cfg_q;
      addr_d    = addr_q;
      mseccfg_d = mseccfg_q;
      wbyte     = '0;
      if (csr_we_i) begin
         if (sel_cfg) begin
            for (int r = 0; r < int'(PMPNumRegions); r++) begin
               wbyte = csr_wdata_i[8*(r%4) +: 8];
               if (csr_addr_i[1:0] == 2'(r >> 2) && !cfg_locked[r] &&
                   !(mseccfg_q.mml && !mseccfg_q.rlb && wbyte[7] &&
                     ({wbyte[0], wbyte[1], wbyte[2]} inside {3'b001, 3'b101, 3'b010, 3'b011})))
                  cfg_d[r] = legalise_cfg(wbyte, cfg_q[r], mseccfg_q.mml);
            end
         end
         if (sel_addr) begin
            for (int r = 0; r < int'(PMPNumRegions); r++)
               if (csr_addr_i[3:0] == 4'(r) && !addr_locked[r]) addr_d[r] = csr_wdata_i;
         end
         if (sel_mseccfg) begin
            mseccfg_d.mml  = mseccfg_q.mml | csr_wdata_i[0];
            mseccfg_d.mmwp = mseccfg_q.mmwp | csr_wdata_i[1];
            if (!any_lock || mseccfg_q.rlb) mseccfg_d.rlb = csr_wdata_i[2];
         end
      end
   end

   always_comb begin
      changed_d = mseccfg_d != mseccfg_q;
      for (int r = 0; r < int'(PMPNumRegions); r++)
         changed_d = changed_d | (cfg_d[r] != cfg_q[r]) | (addr_d[r] != addr_q[r]);
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   // NOTE: these register arrays are architectural state and all get an explicit reset value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cfg_q     <= '{default: '0};
         addr_q    <= '{default: '0};
         mseccfg_q <= '0;
         changed_q <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         addr_q    <= addr_d;
         mseccfg_q <= mseccfg_d;
         changed_q <= changed_d;
      end
   end

   always_comb begin
      cfg_byte  = '{default: '0};
      addr_word = '{default: '0};
      for (int r = 0; r < int'(PMPNumRegions); r++) begin
         addr_rd[r]           = mask_addr(addr_q[r], cfg_q[r].mode);
         csr_pmp_cfg_o[r]     = cfg_q[r];
         csr_pmp_addr_o[r]    = {addr_rd[r], 2'b00};
         cfg_byte[r]          = {cfg_q[r].lock, 2'b00, cfg_q[r].mode, cfg_q[r].exec,
                                 cfg_q[r].write, cfg_q[r].read};
         addr_word[r]         = addr_rd[r];
      end
   end

   always_comb begin
      csr_rdata_o = '0;
      if (sel_cfg) begin
         for (int k = 0; k < 4; k++)
            csr_rdata_o[8*k +: 8] = cfg_byte[{csr_addr_i[1:0], 2'(k)}];
      end else if (sel_addr) begin
         csr_rdata_o = addr_word[csr_addr_i[3:0]];
      end else if (sel_mseccfg) begin
         csr_rdata_o = {29'd0, mseccfg_q};
      end
   end

   assign csr_pmp_mseccfg_o = mseccfg_q;
   assign pmp_cfg_changed_o = changed_q;

`ifdef IBEX_PMP_CSR_SHADOW_EN
   pmp_cfg_t     cfg_sh_q [PMPNumRegions];
   logic [31:0]  addr_sh_q [PMPNumRegions];
   pmp_mseccfg_t mseccfg_sh_q;
   logic         shadow_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cfg_sh_q     <= '{default: '1};
         addr_sh_q    <= '{default: '1};
         mseccfg_sh_q <= '1;
      end else begin
         for (int r = 0; r < int'(PMPNumRegions); r++) begin
            cfg_sh_q[r]  <= pmp_cfg_t'(~cfg_d[r]);
            addr_sh_q[r] <= ~addr_d[r];
         end
         mseccfg_sh_q <= pmp_mseccfg_t'(~mseccfg_d);
      end
   end

   always_comb begin
      shadow_err = mseccfg_q != pmp_mseccfg_t'(~mseccfg_sh_q);
      for (int r = 0; r < int'(PMPNumRegions); r++)
         shadow_err = shadow_err | (cfg_q[r] != pmp_cfg_t'(~cfg_sh_q[r])) |
                      (addr_q[r] != ~addr_sh_q[r]);
   end

   assign shadow_err_o = shadow_err;
`else
   assign shadow_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_pmp_csr_regs.sv
// Directed, table-driven bench for ibex_pmp_csr_regs: one instance with G=0 and one with G=2,
// sharing address/data/reset but with separate write strobes.
module tb_ibex_pmp_csr_regs;
   import ibex_pmp_csr_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         we0 = 1'b0, we2 = 1'b0;
   logic [11:0]  addr = '0;
   logic [31:0]  wdata = '0;

   logic         hit0, hit2, chg0, chg2, serr0, serr2;
   logic [31:0]  rd0, rd2;
   pmp_cfg_t     cfg0 [4], cfg2 [4];
   logic [33:0]  pa0 [4], pa2 [4];
   pmp_mseccfg_t msec0, msec2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ibex_pmp_csr_regs #(.PMPGranularity(0), .PMPNumRegions(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .csr_we_i(we0), .csr_addr_i(addr), .csr_wdata_i(wdata),
      .csr_hit_o(hit0), .csr_rdata_o(rd0), .csr_pmp_cfg_o(cfg0), .csr_pmp_addr_o(pa0),
      .csr_pmp_mseccfg_o(msec0), .pmp_cfg_changed_o(chg0), .shadow_err_o(serr0));

   ibex_pmp_csr_regs #(.PMPGranularity(2), .PMPNumRegions(4)) dut_g (
      .clk_i(clk), .rst_ni(rst_n), .csr_we_i(we2), .csr_addr_i(addr), .csr_wdata_i(wdata),
      .csr_hit_o(hit2), .csr_rdata_o(rd2), .csr_pmp_cfg_o(cfg2), .csr_pmp_addr_o(pa2),
      .csr_pmp_mseccfg_o(msec2), .pmp_cfg_changed_o(chg2), .shadow_err_o(serr2));

   typedef struct {
      bit          rst;
      bit          we;
      logic [11:0] a;
      logic [31:0] d;
      logic [11:0] ra;
      logic [31:0] exp_rd;
      bit          exp_chg;
   } vec_t;

   typedef struct {
      logic [11:0] a;
      bit          exp_hit;
   } hit_t;

   vec_t vecs[$];
   hit_t hits[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add(bit rst, bit we, logic [11:0] a, logic [31:0] d,
                               logic [11:0] ra, logic [31:0] er, bit ec);
      vec_t v;
      v.rst = rst; v.we = we; v.a = a; v.d = d; v.ra = ra; v.exp_rd = er; v.exp_chg = ec;
      vecs.push_back(v);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
   endtask

   // Write at negedge, capture at posedge, then leave the read address on the bus for checking.
   task automatic drive(input bit to_g, input bit we, input logic [11:0] a,
                        input logic [31:0] d, input logic [11:0] ra);
      @(negedge clk);
      we0 = we & ~to_g;
      we2 = we & to_g;
      addr = a;
      wdata = d;
      @(posedge clk);
      #1;
      we0 = 1'b0;
      we2 = 1'b0;
      addr = ra;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Phase A: basic write, TOR lock, reserved encoding, MML stickiness
      add(0, 1, 12'h3A0, 32'h0000_1F0F, 12'h3A0, 32'h0000_1F0F, 1);
      add(0, 0, 12'h3A0, 32'h0,         12'h3A0, 32'h0000_1F0F, 0);
      add(0, 1, 12'h3B1, 32'h0000_1000, 12'h3B1, 32'h0000_1000, 1);
      add(0, 1, 12'h3A0, 32'h0000_8800, 12'h3A0, 32'h0000_8800, 1);
      add(0, 1, 12'h3B0, 32'h0000_0055, 12'h3B0, 32'h0,         0);
      add(0, 1, 12'h3B1, 32'h0000_2000, 12'h3B1, 32'h0000_1000, 0);
      add(0, 1, 12'h3A0, 32'h0000_0F00, 12'h3A0, 32'h0000_8800, 0);
      add(0, 1, 12'h3A0, 32'h0000_880A, 12'h3A0, 32'h0000_8808, 1);
      add(0, 1, 12'h747, 32'h1,         12'h747, 32'h1,         1);
      add(0, 1, 12'h3A0, 32'h0000_880A, 12'h3A0, 32'h0000_880A, 1);
      add(0, 1, 12'h747, 32'h0,         12'h747, 32'h1,         0);
      add(0, 1, 12'h747, 32'h5,         12'h747, 32'h1,         0);
      // Phase B: RLB
      add(1, 1, 12'h747, 32'h4,         12'h747, 32'h4,         1);
      add(0, 1, 12'h3A0, 32'h0000_0080, 12'h3A0, 32'h0000_0080, 1);
      add(0, 1, 12'h747, 32'h0,         12'h747, 32'h0,         1);
      add(0, 1, 12'h747, 32'h4,         12'h747, 32'h0,         0);
      add(0, 1, 12'h3A0, 32'h0,         12'h3A0, 32'h0000_0080, 0);
      // Phase C: MML restriction, reserved bits, unimplemented regions, mseccfgh
      add(1, 1, 12'h747, 32'h1,         12'h747, 32'h1,         1);
      add(0, 1, 12'h3A0, 32'h008C_0000, 12'h3A0, 32'h0,         0);
      add(0, 1, 12'h3A0, 32'h0087_0000, 12'h3A0, 32'h0087_0000, 1);
      add(0, 1, 12'h3A0, 32'h6100_0000, 12'h3A0, 32'h0187_0000, 1);
      add(0, 1, 12'h747, 32'h2,         12'h747, 32'h3,         1);
      add(0, 1, 12'h757, 32'hFFFF_FFFF, 12'h757, 32'h0,         0);
      add(0, 1, 12'h3A1, 32'hFFFF_FFFF, 12'h3A1, 32'h0,         0);
      add(0, 1, 12'h3B5, 32'h0000_1234, 12'h3B5, 32'h0,         0);
      add(0, 1, 12'h3B3, 32'hDEAD_BEEF, 12'h3B3, 32'hDEAD_BEEF, 1);

      hits.push_back('{12'h3A0, 1}); hits.push_back('{12'h3A3, 1});
      hits.push_back('{12'h3A4, 0}); hits.push_back('{12'h3BF, 1});
      hits.push_back('{12'h747, 1}); hits.push_back('{12'h757, 1});
      hits.push_back('{12'h746, 0}); hits.push_back('{12'h39F, 0});

      // Reset state
      #12;
      rst_n = 1'b1;
      @(negedge clk);
      addr = 12'h3A0; #1; check("rst_cfg0", 64'(rd0), 64'h0);
      addr = 12'h3B2; #1; check("rst_addr2", 64'(rd0), 64'h0);
      addr = 12'h747; #1; check("rst_mseccfg", 64'(rd0), 64'h0);
      check("rst_changed", 64'(chg0), 64'h0);
      check("rst_shadow", 64'(serr0), 64'h0);

      foreach (hits[i]) begin
         addr = hits[i].a;
         #1;
         check($sformatf("hit_%0h", hits[i].a), 64'(hit0), 64'(hits[i].exp_hit));
      end

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         drive(1'b0, vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].ra);
         check($sformatf("vec%0d_rdata", i), 64'(rd0), 64'(vecs[i].exp_rd));
         check($sformatf("vec%0d_changed", i), 64'(chg0), 64'(vecs[i].exp_chg));
         check($sformatf("vec%0d_shadow", i), 64'(serr0), 64'h0);
      end

      // Output bus after phase C
      check("bus_cfg2", 64'(cfg0[2]), 64'(6'b1_00_111));
      check("bus_cfg3", 64'(cfg0[3]), 64'(6'b0_00_001));
      check("bus_addr3", 64'(pa0[3]), {30'd0, 32'hDEAD_BEEF, 2'b00});
      check("bus_mseccfg", 64'(msec0), 64'(3'b011));

      // Asynchronous reset in the cycle where the change pulse is high
      drive(1'b0, 1'b1, 12'h3B0, 32'h0000_1234, 12'h3B0);
      check("async_pre_chg", 64'(chg0), 64'h1);
      check("async_pre_rd", 64'(rd0), 64'h1234);
      rst_n = 1'b0;
      #1;
      check("async_chg", 64'(chg0), 64'h0);
      check("async_rd", 64'(rd0), 64'h0);
      rst_n = 1'b1;

      // Granularity 2 instance
      do_reset();
      drive(1'b1, 1'b1, 12'h3A0, 32'h18, 12'h3B0);
      check("g2_napot_rd", 64'(rd2), 64'h1);
      check("g2_napot_bus", 64'(pa2[0]), 64'h4);
      drive(1'b1, 1'b1, 12'h3A0, 32'h00, 12'h3B0);
      check("g2_off_rd", 64'(rd2), 64'h0);
      drive(1'b1, 1'b1, 12'h3B0, 32'hF, 12'h3B0);
      check("g2_off_mask", 64'(rd2), 64'hC);
      check("g2_off_bus", 64'(pa2[0]), 64'h30);
      drive(1'b1, 1'b1, 12'h3A0, 32'h18, 12'h3B0);
      check("g2_napot_f", 64'(rd2), 64'hF);
      drive(1'b1, 1'b1, 12'h3A0, 32'h14, 12'h3A0);
      check("g2_na4_keep", 64'(rd2), 64'h1C);
      check("g2_na4_chg", 64'(chg2), 64'h1);
      check("g2_shadow", 64'(serr2), 64'h0);
      check("g0_untouched", 64'(cfg0[0]), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
